// File: rtl/ml_linear_regression_seq.sv
// Sequential linear-regression engine: one shared signed MAC walks a
// LENGTH-entry weight file, then a single scale step adds the bias and
// presents one fixed-point result per vector on a valid/ready port.
module ml_linear_regression_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned LENGTH    = 16,
  localparam int unsigned IDX_W    = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_we,
  input  logic [IDX_W-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             cfg_err
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  // Headroom for LENGTH full-scale products, so the sum never wraps.
  localparam int unsigned ACC_W  = PROD_W + IDX_W;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCALE  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic        [IDX_W-1:0]   idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [WIDTH-1:0]   w_q [LENGTH];
  logic        [WIDTH-1:0]   w_d [LENGTH];
  logic        [WIDTH-1:0]   bias_q, bias_d;
  logic        [WIDTH-1:0]   out_data_q, out_data_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      cfg_err_q, cfg_err_d;

  logic                      in_fire_c;
  logic                      out_fire_c;
  logic                      w_hit_c;
  logic signed [PROD_W-1:0]  prod_c;

  // Handshakes, address range check and the shared signed multiplier.
  always_comb begin
    in_fire_c  = in_valid & in_ready_q;
    out_fire_c = out_valid_q & out_ready;
    w_hit_c    = (32'(w_addr) < LENGTH);
    prod_c     = PROD_W'($signed(w_q[idx_q])) * PROD_W'($signed(in_data));
  end

  // Next-state logic for the sequencer, accumulator and registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;

    case (state_q)
      ST_ACCUM: begin
        if (in_fire_c) begin
          // The first product overwrites the accumulator, so no clear cycle.
          if (idx_q == '0) begin
            acc_d = ACC_W'(prod_c);
          end else begin
            acc_d = acc_q + ACC_W'(prod_c);
          end
          if (idx_q == IDX_W'(LENGTH - 1)) begin
            idx_d   = '0;
            state_d = ST_SCALE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SCALE: begin
        // Arithmetic shift back to the Q format, then wrap-around bias add.
        out_data_d = WIDTH'(acc_q >>> FRAC_BITS) + bias_q;
        state_d    = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_fire_c) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (idx_d != '0) || (state_d != ST_ACCUM);
  end

  // Configuration writes land only while idle; a dropped write flags cfg_err.
  always_comb begin
    w_d       = w_q;
    bias_d    = bias_q;
    cfg_err_d = (w_we | b_we) & busy_q;
    if (!busy_q) begin
      if (w_we && w_hit_c) begin
        w_d[w_addr] = w_data;
      end
      if (b_we) begin
        bias_d = b_data;
      end
    end
  end

  // All state, including the weight file, is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      for (int i = 0; i < int'(LENGTH); i++) begin
        w_q[i] <= '0;
      end
      bias_q      <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      for (int i = 0; i < int'(LENGTH); i++) begin
        w_q[i] <= w_d[i];
      end
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule
